// File: rtl/order_msg_parser.sv
// Byte-stream framer/decoder for Add/Delete/Update order messages.
// Assembles big-endian frames into a single-entry parallel output register on a
// valid/ready handshake and drops malformed frames.
// Optional: define ORDER_PARSER_STATS_EN to build the msg_count/err_count counters;
// otherwise both outputs are tied to zero.
module order_msg_parser #(
  parameter int unsigned ID_W  = 32,
  parameter int unsigned PX_W  = 32,
  parameter int unsigned QTY_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_msg_type,
  output logic             out_side,
  output logic [ID_W-1:0]  out_order_id,
  output logic [PX_W-1:0]  out_price,
  output logic [QTY_W-1:0] out_quantity,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned TotW    = ID_W + PX_W + QTY_W;
  localparam int unsigned AuBytes = TotW / 8;
  localparam int unsigned DBytes  = ID_W / 8;
  localparam int unsigned BcW     = $clog2(AuBytes);

  localparam logic [7:0] TypeAdd = 8'h41;
  localparam logic [7:0] TypeDel = 8'h44;
  localparam logic [7:0] TypeUpd = 8'h55;
  localparam logic [7:0] SideBid = 8'h42;
  localparam logic [7:0] SideAsk = 8'h53;

  localparam logic [BcW-1:0] LastAu = BcW'(AuBytes - 1);
  localparam logic [BcW-1:0] LastD  = BcW'(DBytes - 1);

  typedef enum logic [1:0] {StIdle, StSide, StFields, StDiscard} state_e;

  state_e           state_q, state_d;
  logic [7:0]       type_q, type_d;
  logic             side_q, side_d;
  logic [BcW-1:0]   bcnt_q, bcnt_d;
  // Holds all field bytes but the one currently on in_data.
  logic [TotW-9:0]  field_q, field_d;
  logic [TotW-1:0]  field_full;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_type_q, out_type_d;
  logic             out_side_q, out_side_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [PX_W-1:0]  out_px_q, out_px_d;
  logic [QTY_W-1:0] out_qty_q, out_qty_d;

  logic accept;
  logic final_byte;
  logic msg_load;
  logic frame_err;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign field_full = {field_q, in_data};
  assign final_byte = (type_q == TypeDel) ? (bcnt_q == LastD) : (bcnt_q == LastAu);

  // Frame FSM next-state: decode type/side, count field bytes, flag errors.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    side_d    = side_q;
    bcnt_d    = bcnt_q;
    field_d   = field_q;
    msg_load  = 1'b0;
    frame_err = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (in_data == TypeAdd || in_data == TypeDel || in_data == TypeUpd) begin
            type_d  = in_data;
            state_d = StSide;
          end else begin
            frame_err = 1'b1;
            state_d   = in_last ? StIdle : StDiscard;
          end
        end
        StSide: begin
          if (in_data == SideBid || in_data == SideAsk) begin
            side_d  = (in_data == SideBid);
            bcnt_d  = '0;
            state_d = StFields;
          end else begin
            frame_err = 1'b1;
            state_d   = in_last ? StIdle : StDiscard;
          end
        end
        StFields: begin
          field_d = field_full[TotW-9:0];
          if (final_byte) begin
            if (in_last) begin
              msg_load = 1'b1;
              state_d  = StIdle;
            end else begin
              frame_err = 1'b1;
              state_d   = StDiscard;
            end
          end else if (in_last) begin
            frame_err = 1'b1;
            state_d   = StIdle;
          end else begin
            bcnt_d = bcnt_q + BcW'(1);
          end
        end
        StDiscard: begin
          if (in_last) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame FSM and field assembly registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      type_q  <= '0;
      side_q  <= 1'b0;
      bcnt_q  <= '0;
      field_q <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      side_q  <= side_d;
      bcnt_q  <= bcnt_d;
      field_q <= field_d;
    end
  end

  // Output register next-state: hold under backpressure, replace on load.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_type_d  = out_type_q;
    out_side_d  = out_side_q;
    out_id_d    = out_id_q;
    out_px_d    = out_px_q;
    out_qty_d   = out_qty_q;
    if (msg_load) begin
      out_valid_d = 1'b1;
      out_type_d  = type_q;
      out_side_d  = side_q;
      if (type_q == TypeDel) begin
        out_id_d  = field_full[ID_W-1:0];
        out_px_d  = '0;
        out_qty_d = '0;
      end else begin
        out_id_d  = field_full[TotW-1 -: ID_W];
        out_px_d  = field_full[PX_W+QTY_W-1 -: PX_W];
        out_qty_d = field_full[QTY_W-1:0];
      end
    end
  end

  // Single-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_type_q  <= '0;
      out_side_q  <= 1'b0;
      out_id_q    <= '0;
      out_px_q    <= '0;
      out_qty_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_type_q  <= out_type_d;
      out_side_q  <= out_side_d;
      out_id_q    <= out_id_d;
      out_px_q    <= out_px_d;
      out_qty_q   <= out_qty_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_msg_type = out_type_q;
  assign out_side     = out_side_q;
  assign out_order_id = out_id_q;
  assign out_price    = out_px_q;
  assign out_quantity = out_qty_q;

`ifdef ORDER_PARSER_STATS_EN
  logic [CNT_W-1:0] msg_cnt_q, err_cnt_q;

  // Saturating message and dropped-frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (msg_load && (msg_cnt_q != '1)) msg_cnt_q <= msg_cnt_q + CNT_W'(1);
      if (frame_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign msg_count = msg_cnt_q;
  assign err_count = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = msg_load ^ frame_err;
  assign msg_count    = '0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_order_msg_parser.sv
// Self-checking bench for order_msg_parser: directed scenarios plus randomized
// frames scored against a frame-level reference model.
module tb_order_msg_parser;

  localparam int ID_W  = 32;
  localparam int PX_W  = 32;
  localparam int QTY_W = 32;
  localparam int CNT_W = 16;
  localparam int MsgW  = 8 + 1 + ID_W + PX_W + QTY_W;
`ifdef ORDER_PARSER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_msg_type;
  logic             out_side;
  logic [ID_W-1:0]  out_order_id;
  logic [PX_W-1:0]  out_price;
  logic [QTY_W-1:0] out_quantity;
  logic [CNT_W-1:0] msg_count;
  logic [CNT_W-1:0] err_count;

  order_msg_parser #(
    .ID_W (ID_W),
    .PX_W (PX_W),
    .QTY_W(QTY_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_msg_type(out_msg_type),
    .out_side    (out_side),
    .out_order_id(out_order_id),
    .out_price   (out_price),
    .out_quantity(out_quantity),
    .msg_count   (msg_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]      frm[$];
  logic [MsgW-1:0] exp_q[$];
  int              pop_cyc[$];
  int              exp_msg = 0;
  int              exp_err = 0;
  int              cyc = 0;
  bit              gaps_en = 1'b0;
  bit              rand_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decide a whole frame at once from its bytes.
  function automatic logic [MsgW:0] model_frame();
    int              n = frm.size();
    int              len;
    logic [7:0]      t;
    logic [7:0]      s;
    logic [ID_W-1:0] id = '0;
    logic [PX_W-1:0] px = '0;
    logic [QTY_W-1:0] qty = '0;
    t = frm[0];
    s = frm[1];
    if (!(t == 8'h41 || t == 8'h44 || t == 8'h55)) return '0;
    if (!(s == 8'h42 || s == 8'h53)) return '0;
    len = (t == 8'h44) ? 2 + ID_W / 8 : 2 + (ID_W + PX_W + QTY_W) / 8;
    if (n != len) return '0;
    for (int i = 0; i < ID_W / 8; i++) id = (id << 8) | ID_W'(frm[2 + i]);
    if (t != 8'h44) begin
      for (int i = 0; i < PX_W / 8; i++) px = (px << 8) | PX_W'(frm[2 + ID_W / 8 + i]);
      for (int i = 0; i < QTY_W / 8; i++)
        qty = (qty << 8) | QTY_W'(frm[2 + (ID_W + PX_W) / 8 + i]);
    end
    return {1'b1, t, (s == 8'h42), id, px, qty};
  endfunction

  task automatic build_msg(input logic [7:0] t, input logic [7:0] s, input logic [31:0] id,
                           input logic [31:0] px, input logic [31:0] qty);
    frm.delete();
    frm.push_back(t);
    frm.push_back(s);
    for (int i = 0; i < 4; i++) frm.push_back(id[31-8*i -: 8]);
    if (t != 8'h44) begin
      for (int i = 0; i < 4; i++) frm.push_back(px[31-8*i -: 8]);
      for (int i = 0; i < 4; i++) frm.push_back(qty[31-8*i -: 8]);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b, input logic last);
    int  waited = 0;
    bit  acc;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 2000) begin
        check_eq("in_timeout", 128'(0), 128'(1));
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
  endtask

  task automatic send_frame();
    logic [MsgW:0] r;
    r = model_frame();
    if (r[MsgW]) begin
      exp_q.push_back(r[MsgW-1:0]);
      exp_msg++;
    end else begin
      exp_err++;
    end
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps_en && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idle_cycle();
      send_byte(frm[i], i == frm.size() - 1);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) idle_cycle();
    check_eq("drain", 128'(exp_q.size()), 128'(0));
    idle_cycle();
    idle_cycle();
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_msg_count"}, 128'(msg_count), StatsEn ? 128'(exp_msg) : 128'(0));
    check_eq({tag, "_err_count"}, 128'(err_count), StatsEn ? 128'(exp_err) : 128'(0));
  endtask

  task automatic random_frame();
    int         kind;
    int         len;
    logic [7:0] t;
    logic [7:0] s;
    kind = $urandom_range(0, 9);
    case ($urandom_range(0, 2))
      0:       t = 8'h41;
      1:       t = 8'h44;
      default: t = 8'h55;
    endcase
    s = ($urandom_range(0, 1) == 1) ? 8'h42 : 8'h53;
    build_msg(t, s, $urandom, $urandom, $urandom);
    len = frm.size();
    if (kind == 6) begin
      t = 8'($urandom_range(0, 255));
      if (t == 8'h41 || t == 8'h44 || t == 8'h55) t = 8'h58;
      frm.delete();
      frm.push_back(t);
      repeat ($urandom_range(2, 15)) frm.push_back(8'($urandom));
    end else if (kind == 7) begin
      s = 8'($urandom_range(0, 255));
      if (s == 8'h42 || s == 8'h53) s = 8'h20;
      frm[1] = s;
    end else if (kind == 8) begin
      while (frm.size() > $urandom_range(3, len - 1)) void'(frm.pop_back());
    end else if (kind == 9) begin
      repeat ($urandom_range(1, 4)) frm.push_back(8'($urandom));
    end
    send_frame();
  endtask

  // Scoreboard: every transfer must match the oldest expected message.
  initial begin
    logic [MsgW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_msg", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("msg", 128'({out_msg_type, out_side, out_order_id, out_price, out_quantity}),
                   128'(e));
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [MsgW-1:0] f1_exp;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) idle_cycle();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_fields", 128'({out_msg_type, out_side, out_order_id, out_price, out_quantity}),
             128'(0));
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_counts("rst");
    idle_cycle();

    // Add bid: latency one cycle after the final byte
    build_msg(8'h41, 8'h42, 32'd7, 32'd100, 32'd10);
    send_frame();
    @(negedge clk);
    check_eq("add_out_valid", 128'(out_valid), 128'(1));
    check_eq("add_fields", 128'({out_msg_type, out_side, out_order_id, out_price, out_quantity}),
             128'({8'h41, 1'b1, 32'd7, 32'd100, 32'd10}));
    check_eq("add_msg_count", 128'(msg_count), StatsEn ? 128'(1) : 128'(0));
    idle_cycle();
    wait_drain();

    // Delete ask then back-to-back Update
    pop_cyc.delete();
    build_msg(8'h44, 8'h53, 32'd7, 32'd0, 32'd0);
    f1_exp = {8'h44, 1'b0, 32'd7, 32'd0, 32'd0};
    check_eq("del_model", 128'(model_frame()), 128'({1'b1, f1_exp}));
    send_frame();
    build_msg(8'h55, 8'h42, 32'd9, 32'd200, 32'd3);
    send_frame();
    wait_drain();
    check_eq("du_pops", 128'(pop_cyc.size()), 128'(2));
    if (pop_cyc.size() == 2) check_eq("du_gap", 128'(pop_cyc[1] - pop_cyc[0]), 128'(14));
    check_counts("du");

    // Backpressure with the next frame already presented
    out_ready = 1'b0;
    f1_exp    = {8'h41, 1'b1, 32'd11, 32'd500, 32'd25};
    fork
      begin
        build_msg(8'h41, 8'h42, 32'd11, 32'd500, 32'd25);
        send_frame();
        build_msg(8'h55, 8'h53, 32'd12, 32'd501, 32'd26);
        send_frame();
      end
      begin
        int k;
        for (k = 0; k < 200; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        check_eq("bp_valid_seen", 128'(out_valid), 128'(1));
        for (int c = 0; c < 5; c++) begin
          if (c != 0) @(negedge clk);
          check_eq("bp_in_ready", 128'(in_ready), 128'(0));
          check_eq("bp_fields",
                   128'({out_msg_type, out_side, out_order_id, out_price, out_quantity}),
                   128'(f1_exp));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check_counts("bp");

    // Unknown type, then a valid Add
    frm.delete();
    frm.push_back(8'h58);
    frm.push_back(8'h01);
    frm.push_back(8'h02);
    frm.push_back(8'h03);
    send_frame();
    build_msg(8'h41, 8'h53, 32'd21, 32'd22, 32'd23);
    send_frame();
    wait_drain();
    check_counts("badtype");

    // Early last on byte 9, late last on byte 16, then resync
    build_msg(8'h41, 8'h42, 32'd31, 32'd32, 32'd33);
    while (frm.size() > 9) void'(frm.pop_back());
    send_frame();
    build_msg(8'h41, 8'h42, 32'd41, 32'd42, 32'd43);
    frm.push_back(8'hAA);
    frm.push_back(8'hBB);
    send_frame();
    build_msg(8'h44, 8'h42, 32'd51, 32'd0, 32'd0);
    send_frame();
    wait_drain();
    check_counts("len");

    // Reset with a pending output, then reset on byte 8 of an Add
    out_ready = 1'b0;
    build_msg(8'h55, 8'h42, 32'd61, 32'd62, 32'd63);
    send_frame();
    in_valid = 1'b1;
    in_data  = 8'h41;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    exp_msg = 0;
    exp_err = 0;
    @(negedge clk);
    check_eq("rst_pend_valid", 128'(out_valid), 128'(0));
    check_eq("rst_pend_fields",
             128'({out_msg_type, out_side, out_order_id, out_price, out_quantity}), 128'(0));
    check_counts("rst_pend");
    idle_cycle();
    out_ready = 1'b1;
    build_msg(8'h41, 8'h42, 32'd71, 32'd72, 32'd73);
    send_frame();
    build_msg(8'h41, 8'h42, 32'd81, 32'd82, 32'd83);
    for (int i = 0; i < 7; i++) send_byte(frm[i], 1'b0);
    in_valid = 1'b1;
    in_data  = frm[7];
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    exp_msg = 0;
    exp_err = 0;
    @(negedge clk);
    check_eq("rst_mid_valid", 128'(out_valid), 128'(0));
    check_counts("rst_mid");
    idle_cycle();
    build_msg(8'h44, 8'h42, 32'd91, 32'd0, 32'd0);
    send_frame();
    build_msg(8'h41, 8'h53, 32'd92, 32'd93, 32'd94);
    send_frame();
    wait_drain();
    check_counts("post_rst");

    // Randomized frames with gaps and random backpressure
    gaps_en    = 1'b1;
    rand_ready = 1'b1;
    repeat (300) random_frame();
    rand_ready = 1'b0;
    gaps_en    = 1'b0;
    out_ready  = 1'b1;
    wait_drain();
    check_counts("random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/order_msg_parser.md
# order_msg_parser

Framing/decode stage that drives the order book's order input. Consumes a byte stream from the market-data receive path, assembles big-endian Add/Delete/Update messages, and presents each complete, well-formed message as one parallel order word (type, side, order_id, price, quantity) on a valid/ready interface. Malformed frames are dropped and counted.

## Interface
- `ID_W`, 32: order_id width in bits; multiple of 8.
- `PX_W`, 32: price width in bits; multiple of 8.
- `QTY_W`, 32: quantity width in bits; multiple of 8.
- `CNT_W`, 16: width of the statistics counters.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a byte is offered.
- `in_data`  in  8  stream byte.
- `in_last`  in  1  byte is the final byte of its frame.
- `in_ready`  out  1  parser accepts the byte this cycle.
- `out_valid`  out  1  `out_*` fields hold a complete message.
- `out_ready`  in  1  downstream takes the message this cycle.
- `out_msg_type`  out  8  0x41 'A', 0x44 'D', 0x55 'U'.
- `out_side`  out  1  1 = bid, 0 = ask.
- `out_order_id`  out  ID_W  order identifier.
- `out_price`  out  PX_W  price; 0 for Delete.
- `out_quantity`  out  QTY_W  quantity; 0 for Delete.
- `msg_count`  out  CNT_W  messages emitted, saturating.
- `err_count`  out  CNT_W  frames dropped, saturating.

## Operation
- Frame layout: type byte, side byte, order_id, then price and quantity (A/U only); multi-byte fields MSB first.
- Frame length: A/U = 2 + (ID_W+PX_W+QTY_W)/8 (14 at defaults); D = 2 + ID_W/8 (6 at defaults).
- Side byte: 0x42 'B' → bid (1); 0x53 'S' → ask (0); any other value is an error.
- A byte is accepted when `in_valid && in_ready`. `in_ready = !out_valid || out_ready` (combinational).
- States:
  - IDLE: expect type byte. Known type → SIDE. Unknown type → error; if `in_last`, stay in IDLE, else DISCARD.
  - SIDE: valid side → FIELDS, byte counter cleared. Invalid side → error → DISCARD, or IDLE if `in_last`.
  - FIELDS: shift bytes into a field register and count them. Final expected byte with `in_last` → load the output register and go to IDLE. Any earlier byte with `in_last` → error → IDLE. Final byte without `in_last` → error → DISCARD.
  - DISCARD: drop accepted bytes until a byte with `in_last`, then IDLE.
- Errors: `err_count` increments exactly once per bad frame. `msg_count` increments when a message is loaded into the output register.
- Both counters saturate at all-ones.
- Output register: a single entry. Fields stay stable while `out_valid && !out_ready`. Delete messages load price and quantity as 0.
- Reset: `out_valid` = 0, all `out_*` fields = 0, counters = 0, state = IDLE. A partially received frame is discarded silently and not counted.

## Timing
- Throughput: one byte per cycle while `out_ready` is high. Back-to-back frames need no gap.
- Latency: `out_valid` rises in the cycle after the final byte is accepted.
- `msg_count` and `err_count` update in the cycle after the deciding byte is accepted.
- Handshake: the message transfers on `out_valid && out_ready`. `out_valid` drops the next cycle unless a new message loads in the same cycle.
- Simultaneous transfer-out and final-byte-in: the new message replaces the old one with no bubble, and `out_valid` stays 1.
- Backpressure: while `out_valid && !out_ready`, `in_ready` = 0. Mid-frame progress freezes; no bytes are lost.
- Reset mid-frame or mid-backpressure: outputs are at reset values in the cycle after `reset` is sampled high.

## Configuration
- `ORDER_PARSER_STATS_EN` defined: `msg_count` and `err_count` are implemented as described.
- Not defined: both outputs are tied to 0 and no counter flops are inferred. Parsing, error handling and the handshake are unchanged.

## Test plan
- Add bid frame 41 42 00000007 00000064 0000000A with last on byte 14, `out_ready` = 1 → one cycle later: `out_valid` = 1, type 0x41, side 1, id 7, price 100, qty 10; `msg_count` = 1.
- Delete ask frame 44 53 00000007 → type 0x44, side 0, id 7, price 0, qty 0. The next Update frame sent back-to-back is emitted 14 cycles later.
- `out_ready` held 0 for 5 cycles with a message pending and the next frame already started → `in_ready` = 0; fields stable. After release, both messages are delivered in order, intact.
- Frame type 0x58 followed by 3 bytes, last on the 4th → no output, `err_count` = 1. A following valid Add is emitted normally.
- Add frame with `in_last` on byte 9 → dropped, `err_count` +1. An Add frame whose `in_last` only arrives on byte 16 → dropped, `err_count` +1, parser resyncs.
- `reset` asserted on byte 8 of an Add → `out_valid` = 0 and counters = 0 the next cycle. A fresh frame after reset decodes correctly. Repeat the suite with `ORDER_PARSER_STATS_EN` undefined: counters are 0 and outputs are otherwise identical.
